// File: rtl/div_16b_seq.sv
// Sequential 16-bit radix-2 restoring divider, one quotient bit per clock, 17-cycle latency.
// Define DIV_SIGNED_EN for two's-complement operands (magnitude divide plus sign fixup in DONE).
module div_16b_seq (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [15:0] dividend,
   input  logic [15:0] divisor,
   output logic        busy,
   output logic        done,
   output logic [15:0] quotient,
   output logic [15:0] remainder,
   output logic        div_by_zero
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t      state;
   logic [15:0] p_reg;
   logic [15:0] q_reg;
   logic [15:0] dsr;
   logic [3:0]  cnt;

`ifdef DIV_SIGNED_EN
   logic [15:0] dvd_raw;
   logic        dvd_neg;
   logic        dsr_neg;
`endif

   // Two-level carry-lookahead: 4-bit group generate/propagate, lookahead across groups.
   function automatic logic [16:0] cla_add16(input logic [15:0] a, input logic [15:0] b,
                                             input logic cin);
      logic [15:0] g;
      logic [15:0] p;
      logic [3:0]  gg;
      logic [3:0]  pg;
      logic [4:0]  gc;
      logic [15:0] c;
      g = a & b;
      p = a ^ b;
      for (int i = 0; i < 4; i++) begin
         gg[i] = g[4*i+3] | (p[4*i+3] & g[4*i+2]) | (p[4*i+3] & p[4*i+2] & g[4*i+1])
               | (p[4*i+3] & p[4*i+2] & p[4*i+1] & g[4*i]);
         pg[i] = &p[4*i +: 4];
      end
      gc[0] = cin;
      gc[1] = gg[0] | (pg[0] & cin);
      gc[2] = gg[1] | (pg[1] & gg[0]) | (pg[1] & pg[0] & cin);
      gc[3] = gg[2] | (pg[2] & gg[1]) | (pg[2] & pg[1] & gg[0]) | (pg[2] & pg[1] & pg[0] & cin);
      gc[4] = gg[3] | (pg[3] & gg[2]) | (pg[3] & pg[2] & gg[1]) | (pg[3] & pg[2] & pg[1] & gg[0])
            | (pg[3] & pg[2] & pg[1] & pg[0] & cin);
      c = '0;
      for (int i = 0; i < 4; i++) begin
         c[4*i] = gc[i];
         for (int j = 0; j < 3; j++) begin
            c[4*i+j+1] = g[4*i+j] | (p[4*i+j] & c[4*i+j]);
         end
      end
      return {gc[4], p ^ c};
   endfunction

   logic [16:0] p_sh;
   logic [16:0] sub_res;
   logic        diff_neg;
   logic [15:0] q_fix;
   logic [15:0] r_fix;

   // P is always below the divisor after an iteration, so its bit 16 stays zero
   // and only the low 16 bits are stored; P' still carries the shifted-out bit.
   always_comb begin
      p_sh     = {p_reg, q_reg[15]};
      sub_res  = cla_add16(p_sh[15:0], ~dsr, 1'b1);
      diff_neg = ~(p_sh[16] ^ sub_res[16]);
   end

   always_comb begin
`ifdef DIV_SIGNED_EN
      q_fix = (dvd_neg ^ dsr_neg) ? (~q_reg + 16'd1) : q_reg;
      r_fix = dvd_neg ? (~p_reg + 16'd1) : p_reg;
      if (dsr == 16'd0) begin
         q_fix = 16'hFFFF;
         r_fix = dvd_raw;
      end
`else
      q_fix = q_reg;
      r_fix = p_reg;
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         busy        <= 1'b0;
         done        <= 1'b0;
         quotient    <= 16'd0;
         remainder   <= 16'd0;
         div_by_zero <= 1'b0;
         p_reg       <= 16'd0;
         q_reg       <= 16'd0;
         dsr         <= 16'd0;
         cnt         <= 4'd0;
`ifdef DIV_SIGNED_EN
         dvd_raw     <= 16'd0;
         dvd_neg     <= 1'b0;
         dsr_neg     <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               // busy is only still high here during the done cycle
               if (busy) begin
                  busy <= 1'b0;
               end else if (start) begin
`ifdef DIV_SIGNED_EN
                  q_reg   <= dividend[15] ? (~dividend + 16'd1) : dividend;
                  dsr     <= divisor[15] ? (~divisor + 16'd1) : divisor;
                  dvd_raw <= dividend;
                  dvd_neg <= dividend[15];
                  dsr_neg <= divisor[15];
`else
                  q_reg   <= dividend;
                  dsr     <= divisor;
`endif
                  p_reg <= 16'd0;
                  cnt   <= 4'd0;
                  busy  <= 1'b1;
                  state <= RUN;
               end
            end
            RUN: begin
               p_reg <= diff_neg ? p_sh[15:0] : sub_res[15:0];
               q_reg <= {q_reg[14:0], ~diff_neg};
               cnt   <= cnt + 4'd1;
               if (cnt == 4'd15) begin
                  state <= DONE;
               end
            end
            DONE: begin
               quotient    <= q_fix;
               remainder   <= r_fix;
               div_by_zero <= (dsr == 16'd0);
               done        <= 1'b1;
               state       <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
